// File: rtl/snn_fifo_wr_arb_if.sv
// Write-side bus between spike-event requesters, the arbiter and an async_fifo write port.
// Optional source tagging widens wdata when SNN_ARB_SRC_TAG_EN is defined.
interface snn_fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int IDW = $clog2(NREQ);
`ifdef SNN_ARB_SRC_TAG_EN
    localparam int FW = DSIZE + IDW;
`else
    localparam int FW = DSIZE;
`endif

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [FW-1:0]         wdata;
    logic                  wfull;

    // Requesters and FIFO status side
    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata
    );
endinterface

// File: rtl/snn_fifo_wr_arb.sv
// Packet-level round-robin arbiter sharing one async_fifo write port among NREQ requesters.
// Define SNN_ARB_SRC_TAG_EN to prepend the granted requester index to wdata.
module snn_fifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    snn_fifo_wr_arb_if.slave           bus,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy,
    output logic                       err_len
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_owner;
    logic [7:0]       r_beats;
    logic             r_err_len;

    logic             w_found;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_sel;
    logic [NREQ-1:0]  w_ready;
    logic             w_xfer;
    logic             w_last;
    logic [DSIZE-1:0] w_payload;
    logic [7:0]       w_beats_inc;
    logic             w_beats_max;

    // Rotating priority search starting at r_ptr; NREQ is a power of two so IDW-bit add wraps.
    always_comb begin
        logic [IDW-1:0] idx;
        w_found = 1'b0;
        w_cand  = r_ptr;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = r_ptr + IDW'(k);
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_cand  = idx;
            end
        end
    end

    always_comb begin
        w_sel   = (r_state == S_LOCK) ? r_owner : w_cand;
        w_ready = '0;
        if (!rst && !bus.wfull && (r_state == S_LOCK || w_found))
            w_ready[w_sel] = 1'b1;
        w_xfer    = |(w_ready & bus.req_valid);
        w_last    = bus.req_last[w_sel];
        w_payload = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_sel)
                w_payload = bus.req_data[k*DSIZE +: DSIZE];
        end
        w_beats_inc = r_beats + 8'd1;
        w_beats_max = (w_beats_inc == 8'(MAXBEATS));
    end

    assign bus.req_ready = w_ready;
    assign bus.winc      = w_xfer;
`ifdef SNN_ARB_SRC_TAG_EN
    assign bus.wdata     = {w_sel, w_payload};
`else
    assign bus.wdata     = w_payload;
`endif
    assign grant_id      = w_sel;
    assign busy          = (r_state == S_LOCK);
    assign err_len       = r_err_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_beats   <= '0;
            r_err_len <= 1'b0;
        end else if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    if (w_last) begin
                        r_ptr <= w_cand + IDW'(1);
                    end else if (8'd1 == 8'(MAXBEATS)) begin
                        // Degenerate single-beat limit: the opening beat already hits the cap
                        r_ptr     <= w_cand + IDW'(1);
                        r_err_len <= 1'b1;
                    end else begin
                        r_state <= S_LOCK;
                        r_owner <= w_cand;
                        r_beats <= 8'd1;
                    end
                end
                S_LOCK: begin
                    r_beats <= w_beats_inc;
                    if (w_last || w_beats_max) begin
                        r_state <= S_IDLE;
                        r_ptr   <= r_owner + IDW'(1);
                        if (!w_last)
                            r_err_len <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/snn_fifo_wr_arb.md
# snn_fifo_wr_arb

Packet-level round-robin arbiter that shares the single write port of an `async_fifo` instance among `NREQ` spike-event requesters in the write-clock domain. It accepts beats over per-requester valid/ready handshakes and drives `winc`/`wdata` directly. It honours `wfull` and holds a grant for a whole packet, so packets from different sources never interleave in the FIFO.

## Interface
- `NREQ`, 4: number of requesters; power of two, 2..16.
- `DSIZE`, 8: payload width per beat.
- `MAXBEATS`, 16: maximum beats per packet before forced release; at most 255.
- `IDW`, $clog2(NREQ): requester-index width. Derived; not to be overridden.
- `clk` in 1: single clock. It is the FIFO write clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester beat valid.
- `req_last` in NREQ: marks the final beat of a packet; sampled with the beat.
- `req_data` in NREQ*DSIZE: requester i payload occupies bits [i*DSIZE +: DSIZE].
- `req_ready` out NREQ: per-requester beat accept.
- `winc` out 1: FIFO write strobe.
- `wdata` out FW: FIFO write data; FW is defined under Configuration.
- `wfull` in 1: FIFO full flag, synchronous to `clk`.
- `grant_id` out IDW: index of the current or selected requester.
- `busy` out 1: high while in LOCK state.
- `err_len` out 1: sticky flag set by a forced release.

## Operation
- A beat transfers in a cycle when `req_valid[i] && req_ready[i]`.
- `winc` = OR of all transfers, and at most one transfer occurs per cycle. `wdata` carries the granted requester's payload.
- `req_ready` is never asserted while `wfull=1`. The FIFO is therefore never written when full.
- Registered state: `state` (IDLE/LOCK), `ptr` (IDW), `owner` (IDW), `beats` (8 bit), `err_len`.
- IDLE state:
  - The candidate is the first `i` with `req_valid[i]`, searching from `ptr` upward with wrap-around.
  - `grant_id` = candidate. `req_ready[candidate]` = `!wfull`; all other ready bits are 0.
  - A transfer with `req_last=1` is a single-beat packet: stay in IDLE and set `ptr` ← candidate+1 (mod NREQ).
  - A transfer with `req_last=0`: go to LOCK, set `owner` ← candidate and `beats` ← 1.
  - If no requester is valid: `grant_id` = `ptr` and all ready bits are 0.
- LOCK state:
  - `grant_id` = `owner`. Only `req_ready[owner]` can assert, and it equals `!wfull`. Other requesters stall even when valid.
  - On each owner transfer, `beats` increments.
  - A transfer with `req_last=1` returns to IDLE with `ptr` ← owner+1.
  - A transfer with `req_last=0` that brings `beats` to MAXBEATS forces a return to IDLE: set `ptr` ← owner+1 and `err_len` ← 1.
  - Owner gaps (`req_valid[owner]=0`) hold LOCK indefinitely. There is no timeout.
- `err_len` clears only on reset.
- `busy` = (state == LOCK).

## Timing
- Reset values: state IDLE, `ptr`=0, `owner`=0, `beats`=0, `err_len`=0. `req_ready`=0 and `winc`=0 while `rst` is high.
- Zero-latency path: `req_valid`/`wfull` → `req_ready` → `winc`/`wdata` is combinational within the same cycle. The state update occurs at the next `clk` edge.
- A new arbitration decision takes effect in the cycle after a packet ends. There are no idle bubbles between back-to-back packets from different sources.
- `wfull` asserting mid-packet stalls the owner. Ownership is kept.
- Reset asserted mid-packet abandons the packet. The remaining beats from that requester are then treated as a new packet.
- `ptr` wraps from NREQ-1 to 0.
- Simultaneous `req_valid` from all requesters: grant order is `ptr`, `ptr`+1, and so on.

## Configuration
- `SNN_ARB_SRC_TAG_EN` defined:
  - FW = DSIZE+IDW.
  - `wdata` = {grant_id, payload}, so the reader can recover the source.
  - The FIFO must be instantiated with DSIZE+IDW.
- `SNN_ARB_SRC_TAG_EN` undefined:
  - FW = DSIZE and `wdata` = payload.
  - No tag logic is present.

## Test plan
- Reset, then requesters 0..3 all valid with single-beat packets (data 0x10,0x20,0x30,0x40, last=1), `wfull`=0 → FIFO receives 0x10,0x20,0x30,0x40 in 4 consecutive cycles. `ptr` returns to 0.
- Requester 1 sends a 3-beat packet (0xA1,0xA2,0xA3 last) while requester 2 holds a valid beat (0xB1) throughout → order A1,A2,A3,B1. `busy` is high for the middle beats. `req_ready[2]`=0 until A3 transfers.
- Owner mid-packet with `wfull` forced to 1 for 5 cycles → `winc`=0 and all ready bits are 0 for those 5 cycles. `busy` stays 1. The packet resumes in order.
- Requester 3 streams 16 beats with last=0 (MAXBEATS=16) → after beat 16: state IDLE, `err_len`=1, `ptr`=0. Requester 0, if valid, is granted next.
- Assert `rst` during a 4-beat packet after beat 2 → outputs go to reset values immediately. After release, `ptr`=0 and `err_len`=0.
- With `SNN_ARB_SRC_TAG_EN` defined, NREQ=4: requester 2 writes 0x5A → `wdata`=0x25A, 10 bits wide.
